// File: rtl/add_round_key_stream_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// add_round_key_stream_if
// Bundles the key-load port and both valid/ready stream ports of the
// column-serial AddRoundKey stage.
//   key_we / key_waddr / key_wdata : round-key store write port
//   in_valid / in_ready / in_round / in_data  : input beat stream
//   in_inv (AES_ARK_INV_ORDER_EN only)        : decryption key order
//   out_valid / out_ready / out_data / out_last / out_err : output beats
// Modports: slave = the AddRoundKey stage, master = the block driving it.
// Optional feature macro: AES_ARK_INV_ORDER_EN (adds in_inv).
// ---------------------------------------------------------------------------
interface add_round_key_stream_if #(
    parameter int NB   = 4,
    parameter int COLS = 1,
    parameter int NR   = 10
);
    localparam int RW = $clog2(NR + 1);

    logic                 key_we;
    logic [RW-1:0]        key_waddr;
    logic [32*NB-1:0]     key_wdata;

    logic                 in_valid;
    logic                 in_ready;
    logic [RW-1:0]        in_round;
`ifdef AES_ARK_INV_ORDER_EN
    logic                 in_inv;
`endif
    logic [32*COLS-1:0]   in_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [32*COLS-1:0]   out_data;
    logic                 out_last;
    logic                 out_err;

    modport slave (
`ifdef AES_ARK_INV_ORDER_EN
        input  in_inv,
`endif
        input  key_we, key_waddr, key_wdata,
        input  in_valid, in_round, in_data,
        output in_ready,
        output out_valid, out_data, out_last, out_err,
        input  out_ready
    );

    modport master (
`ifdef AES_ARK_INV_ORDER_EN
        output in_inv,
`endif
        output key_we, key_waddr, key_wdata,
        output in_valid, in_round, in_data,
        input  in_ready,
        input  out_valid, out_data, out_last, out_err,
        output out_ready
    );
endinterface

// File: rtl/add_round_key_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// add_round_key_stream
// Streaming, column-serial AddRoundKey stage. An AES state of NB 32-bit
// columns arrives as BEATS = NB/COLS beats of COLS columns; each beat is
// XORed with the matching columns of one round key taken from an internal
// store of NR+1 keys, through a single registered valid/ready stage.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low (clears pipeline and key store)
//   bus   : add_round_key_stream_if.slave
//           key_we/key_waddr/key_wdata : load one round key
//           in_valid/in_ready/in_round/in_data : input beats (in_round is
//             sampled on the first beat of a block only)
//           out_valid/out_ready/out_data/out_last/out_err : output beats
//
// Optional feature macro: AES_ARK_INV_ORDER_EN
//   When defined, bus.in_inv is sampled with in_round on the first beat and,
//   when set, selects round key NR - in_round (decryption order).
// ---------------------------------------------------------------------------
module add_round_key_stream #(
    parameter int NB   = 4,
    parameter int COLS = 1,
    parameter int NR   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    add_round_key_stream_if.slave   bus
);

    localparam int RW    = $clog2(NR + 1);
    localparam int BEATS = NB / COLS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // The store is sized to the full index space so every RW-bit index is a
    // legal array address; entries above NR are never written and stay zero.
    localparam int DEPTH = 1 << RW;

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);

    // Elaboration-time parameter sanity.
    if ((COLS < 1) || ((NB % COLS) != 0)) begin : g_bad_cols
        $error("add_round_key_stream: COLS must divide NB");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [32*NB-1:0]   key_mem [DEPTH];
    logic [BW-1:0]      beat_q;
    logic [RW-1:0]      held_round_q;
    logic               held_err_q;

    logic               out_valid_q;
    logic [32*COLS-1:0] out_data_q;
    logic               out_last_q;
    logic               out_err_q;

    // ---------------------------------------------------------------------
    // Handshake: one stage, a slot frees up whenever the current beat leaves.
    // ---------------------------------------------------------------------
    logic accept;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------------------------------------------------------------
    // Round selection: beat 0 takes the index from the input, later beats
    // reuse the index captured at beat 0 so in_round may change freely.
    // ---------------------------------------------------------------------
    logic               first_beat;
    logic [RW-1:0]      eff_round;
    logic               eff_err;

    always_comb begin
        first_beat = (beat_q == '0);
        eff_round  = held_round_q;
        eff_err    = held_err_q;
        if (first_beat) begin
            eff_err = (bus.in_round > LAST_ROUND);
`ifdef AES_ARK_INV_ORDER_EN
            // Out-of-range input wraps here, but eff_err forces a zero key.
            eff_round = bus.in_inv ? (LAST_ROUND - bus.in_round) : bus.in_round;
`else
            eff_round = bus.in_round;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Key column fetch. Reads the registered store, so a write in the same
    // cycle as an accepted beat is only visible to later beats.
    // ---------------------------------------------------------------------
    logic [32*NB-1:0]   key_sel;
    logic [32*COLS-1:0] key_cols;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        key_sel  = eff_err ? '0 : key_mem[eff_round];
        key_cols = '0;
        for (int c = 0; c < COLS; c++) begin
            key_cols[32*c +: 32] = key_sel[32*(int'(beat_q)*COLS + c) +: 32];
        end
    end

    // ---------------------------------------------------------------------
    // Key store
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the store is reset explicitly because the cipher relies
            // on it reading as all-zero until reloaded; this costs a reset
            // tree on every bit, so only memories with that need get one.
            for (int i = 0; i < DEPTH; i++) begin
                key_mem[i] <= '0;
            end
        end else if (bus.key_we && (bus.key_waddr <= LAST_ROUND)) begin
            key_mem[bus.key_waddr] <= bus.key_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Beat counter and held round index
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q       <= '0;
            held_round_q <= '0;
            held_err_q   <= 1'b0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            if (beat_q == LAST_BEAT) begin
                beat_q <= '0;
            end else begin
                beat_q <= beat_q + 1'b1;
            end
            if (first_beat) begin
                held_round_q <= eff_round;
                held_err_q   <= eff_err;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output register: loads on accept, holds while stalled, and drops
    // valid once the beat has been taken with nothing new behind it.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data ^ key_cols;
            out_last_q  <= (beat_q == LAST_BEAT);
            out_err_q   <= eff_err;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

endmodule
